// File: rtl/calfifo_rd_arbiter_pkg.sv
// rtl/calfifo_rd_arbiter_pkg.sv - state encoding and width helpers for the calfifo read arbiter
// Contents: arb_state_e (IDLE/GRANT/XFER), chw() channel-index width, cntw() burst counter width.
package calfifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_e;

    // Channel index width; a single channel still needs one bit.
    function automatic int chw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Burst counter width; must hold BURST_LEN-1 and compare before incrementing.
    function automatic int cntw(input int b);
        return (b <= 1) ? 1 : $clog2(b + 1);
    endfunction

endpackage

// File: rtl/calfifo_rd_arbiter_if.sv
// rtl/calfifo_rd_arbiter_if.sv - tagged output word stream of the calfifo read arbiter
// Signals: m_valid/m_ready handshake, m_data word, m_chan source channel, m_sof first word of grant.
// Modports: master (arbiter side), slave (packetiser side).
interface calfifo_rd_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int CHW    = 2
);
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic [CHW-1:0]    m_chan;
    logic              m_sof;

    modport master (output m_valid, output m_data, output m_chan, output m_sof, input m_ready);
    modport slave  (input m_valid, input m_data, input m_chan, input m_sof, output m_ready);
endinterface

// File: rtl/calfifo_rd_arbiter_rr_pick.sv
// rtl/calfifo_rd_arbiter_rr_pick.sv - rotate-priority encoder for the calfifo read arbiter
// Ports: req (per-channel request), rr_ptr (highest-priority channel),
//        grant (first requester at or after rr_ptr, wrapping), any (some request present).
module calfifo_rr_pick
    import calfifo_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CHW    = chw(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CHW-1:0]    rr_ptr,
    output logic [CHW-1:0]    grant,
    output logic              any
);

    always_comb begin
        int             sum;
        logic [CHW-1:0] idx;
        sum   = 0;
        idx   = '0;
        grant = '0;
        any   = 1'b0;
        // Walk offsets far-to-near so the nearest requester to rr_ptr is written last and wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            idx = CHW'(sum);
            if (req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/calfifo_rd_arbiter.sv
// rtl/calfifo_rd_arbiter.sv - round-robin burst read scheduler draining FWFT calibration FIFOs
// Ports: pos_rclk clock; aresetn_rclk async / sresetn_rclk sync active-low resets;
//        enable (new grants allowed); ch_mask (eligible channels); ch_empty/ch_dout FWFT FIFO side;
//        ch_rd_en one-hot pop; m_if master stream (m_valid/m_ready/m_data/m_chan/m_sof);
//        busy (state not IDLE or a word still held).
module calfifo_rd_arbiter
    import calfifo_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DWIDTH    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic                     pos_rclk,
    input  logic                     aresetn_rclk,
    input  logic                     sresetn_rclk,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH-1:0]        ch_empty,
    input  logic [NUM_CH*DWIDTH-1:0] ch_dout,
    output logic [NUM_CH-1:0]        ch_rd_en,
    calfifo_rd_arbiter_if.master     m_if,
    output logic                     busy
);

    localparam int CHW  = chw(NUM_CH);
    localparam int CNTW = cntw(BURST_LEN);

    arb_state_e        state;
    logic [CHW-1:0]    rr_ptr;
    logic [CHW-1:0]    grant;
    logic [CNTW-1:0]   burst_cnt;
    logic              sof_pend;

    logic [NUM_CH-1:0] req;
    logic [CHW-1:0]    pick;
    logic              pick_any;
    logic              grant_empty;
    logic              pop;
    logic              burst_last;
    logic              grant_done;
    logic [DWIDTH-1:0] dout_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign dout_arr[i] = ch_dout[i*DWIDTH +: DWIDTH];
    end

    assign req         = ch_mask & ~ch_empty;
    assign grant_empty = ch_empty[grant];
    // Pop only when the output register is free or being drained this cycle.
    assign pop         = (state == ST_XFER) & ~grant_empty & (~m_if.m_valid | m_if.m_ready);
    assign burst_last  = (burst_cnt == CNTW'(BURST_LEN - 1));
    // An empty granted FIFO ends the grant early; ch_mask is not consulted mid-burst.
    assign grant_done  = (state == ST_XFER) & ((pop & burst_last) | grant_empty);
    assign busy        = (state != ST_IDLE) | m_if.m_valid;

    always_comb begin
        ch_rd_en = '0;
        if (pop) begin
            ch_rd_en[grant] = 1'b1;
        end
    end

    calfifo_rr_pick #(
        .NUM_CH (NUM_CH),
        .CHW    (CHW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick),
        .any    (pick_any)
    );

    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            burst_cnt    <= '0;
            sof_pend     <= 1'b0;
            m_if.m_valid <= 1'b0;
            m_if.m_data  <= '0;
            m_if.m_chan  <= '0;
            m_if.m_sof   <= 1'b0;
        end else if (!sresetn_rclk) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            burst_cnt    <= '0;
            sof_pend     <= 1'b0;
            m_if.m_valid <= 1'b0;
            m_if.m_data  <= '0;
            m_if.m_chan  <= '0;
            m_if.m_sof   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && (|req)) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Requests seen in IDLE/XFER may have vanished by now.
                    if (pick_any) begin
                        grant     <= pick;
                        burst_cnt <= '0;
                        sof_pend  <= 1'b1;
                        rr_ptr    <= (pick == CHW'(NUM_CH - 1)) ? '0 : pick + 1'b1;
                        state     <= ST_XFER;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (pop) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (grant_done) begin
                        state <= (enable && (|req)) ? ST_GRANT : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (pop) begin
                m_if.m_valid <= 1'b1;
                m_if.m_data  <= dout_arr[grant];
                m_if.m_chan  <= grant;
                m_if.m_sof   <= sof_pend;
                sof_pend     <= 1'b0;
            end else if (m_if.m_ready) begin
                m_if.m_valid <= 1'b0;
            end
        end
    end

endmodule
